// File: rtl/shift_lane_pkg.sv
// Shared types, default sizes and the lane-index helper for the symbol-lane shifter.
package shift_lane_pkg;

  typedef enum logic [1:0] {
    MODE_RFILL  = 2'b00,
    MODE_RARITH = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_LFILL  = 2'b11
  } mode_e;

  localparam int DEF_SYM_W     = 5;
  localparam int DEF_LANES     = 10;
  localparam int DEF_MAX_SHIFT = 4;

  // Source lane feeding output lane 'lane' for a shift of 'amt'; -1 means "take the fill symbol".
  function automatic int lane_src(input int lane, input int amt, input int lanes,
                                  input bit left, input bit rot);
    int src;
    src = left ? (lane - amt) : (lane + amt);
    if (rot) begin
      src = ((src % lanes) + lanes) % lanes;
    end else if ((src < 0) || (src >= lanes)) begin
      src = -1;
    end
    return src;
  endfunction

endpackage

// File: rtl/shift_lane_core.sv
// Combinational symbol-lane shifter: one mux stage per shift bit, plus out-of-range override.
module shift_lane_core
  import shift_lane_pkg::*;
#(
  parameter int SYM_W     = DEF_SYM_W,
  parameter int LANES     = DEF_LANES,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  parameter int SHIFT_W   = 4
) (
  input  logic [LANES*SYM_W-1:0] data_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  input  logic [1:0]             mode_i,
  input  logic [SYM_W-1:0]       fill_i,
  output logic [LANES*SYM_W-1:0] data_o,
  output logic                   range_ok_o
);

  localparam int W = LANES * SYM_W;
  localparam logic [SHIFT_W-1:0] MAX_K = SHIFT_W'(MAX_SHIFT);

  mode_e            mode;
  logic [SYM_W-1:0] sign_sym;
  logic [SYM_W-1:0] fill_sym;
  logic [W-1:0]     shifted;

  assign mode       = mode_e'(mode_i);
  assign sign_sym   = data_i[(LANES-1)*SYM_W +: SYM_W];
  assign fill_sym   = (mode == MODE_RARITH) ? sign_sym : fill_i;
  assign range_ok_o = (shift_i <= MAX_K);

  genvar gi, gj;
  generate
    for (gi = 0; gi < SHIFT_W; gi++) begin : g_stage
      logic [W-1:0] prev;
      logic [W-1:0] nxt;

      if (gi == 0) begin : g_first
        assign prev = data_i;
      end else begin : g_chain
        assign prev = g_stage[gi-1].nxt;
      end

      for (gj = 0; gj < LANES; gj++) begin : g_lane
        localparam int AMT     = 1 << gi;
        localparam int SRC_R   = lane_src(gj, AMT, LANES, 1'b0, 1'b0);
        localparam int SRC_L   = lane_src(gj, AMT, LANES, 1'b1, 1'b0);
        localparam int SRC_ROT = lane_src(gj, AMT, LANES, 1'b0, 1'b1);

        logic [SYM_W-1:0] r_sym;
        logic [SYM_W-1:0] l_sym;
        logic [SYM_W-1:0] rot_sym;
        logic [SYM_W-1:0] moved;

        if (SRC_R >= 0) begin : g_r
          assign r_sym = prev[SRC_R*SYM_W +: SYM_W];
        end else begin : g_rf
          assign r_sym = fill_sym;
        end

        if (SRC_L >= 0) begin : g_l
          assign l_sym = prev[SRC_L*SYM_W +: SYM_W];
        end else begin : g_lf
          assign l_sym = fill_sym;
        end

        assign rot_sym = prev[SRC_ROT*SYM_W +: SYM_W];
        assign moved   = (mode == MODE_ROT)   ? rot_sym :
                         (mode == MODE_LFILL) ? l_sym   : r_sym;
        assign nxt[gj*SYM_W +: SYM_W] = shift_i[gi] ? moved : prev[gj*SYM_W +: SYM_W];
      end
    end
  endgenerate

  assign shifted = g_stage[SHIFT_W-1].nxt;

  // Out-of-range shifts never use the staged result; the mode picks a fixed pattern instead.
  always_comb begin
    data_o = shifted;
    if (!range_ok_o) begin
      case (mode)
        MODE_ROT:    data_o = data_i;
        MODE_RARITH: data_o = {LANES{sign_sym}};
        default:     data_o = {LANES{fill_i}};
      endcase
    end
  end

endmodule

// File: rtl/shift_lane_pipe.sv
// Registered valid/ready wrapper around shift_lane_core with a saturating out-of-range counter.
module shift_lane_pipe
  import shift_lane_pkg::*;
#(
  parameter int SYM_W     = DEF_SYM_W,
  parameter int LANES     = DEF_LANES,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  parameter int SHIFT_W   = 4,
  parameter int ERR_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*SYM_W-1:0] in_data,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic [1:0]             in_mode,
  input  logic [SYM_W-1:0]       in_fill,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*SYM_W-1:0] out_data,
  output logic                   out_range_ok,
  output logic [ERR_W-1:0]       err_cnt,
  input  logic                   clr_err
);

  localparam int W = LANES * SYM_W;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_range_ok_q, out_range_ok_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_base;
  logic [W-1:0]     core_data;
  logic             core_ok;
  logic             accept;

  shift_lane_core #(
    .SYM_W    (SYM_W),
    .LANES    (LANES),
    .MAX_SHIFT(MAX_SHIFT),
    .SHIFT_W  (SHIFT_W)
  ) u_core (
    .data_i    (in_data),
    .shift_i   (in_shift),
    .mode_i    (in_mode),
    .fill_i    (in_fill),
    .data_o    (core_data),
    .range_ok_o(core_ok)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_range_ok_d = out_range_ok_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_data_d     = core_data;
      out_range_ok_d = core_ok;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear applies first so a counted beat in the same cycle leaves the count at one.
    err_base  = clr_err ? '0 : err_cnt_q;
    err_cnt_d = err_base;
    if (accept && !core_ok && (err_base != '1)) begin
      err_cnt_d = err_base + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_range_ok_q <= 1'b1;
      err_cnt_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_range_ok_q <= out_range_ok_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_range_ok = out_range_ok_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_shift_lane_pipe.sv
// Directed bench for shift_lane_pipe at default sizes; expected words written out lane by lane.
module tb_shift_lane_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [49:0] in_data = '0;
  logic [3:0]  in_shift = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_fill = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [49:0] out_data;
  logic        out_range_ok;
  logic [15:0] err_cnt;
  logic        clr_err = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [49:0] d_base, b1, b2, b3;

  shift_lane_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shift    (in_shift),
    .in_mode     (in_mode),
    .in_fill     (in_fill),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_range_ok(out_range_ok),
    .err_cnt     (err_cnt),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Arguments are lanes 0..9 in order.
  function automatic logic [49:0] w(input int l0, input int l1, input int l2, input int l3,
                                    input int l4, input int l5, input int l6, input int l7,
                                    input int l8, input int l9);
    return {5'(l9), 5'(l8), 5'(l7), 5'(l6), 5'(l5), 5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("pass %s = %h", tag, obs);
    end
  endtask

  // Presents one beat for a single edge; called at edge+1 so inputs settle away from the edge.
  task automatic send(input logic [49:0] d, input int k, input int m, input int f,
                      input bit clr = 1'b0);
    in_data  = d;
    in_shift = 4'(k);
    in_mode  = 2'(m);
    in_fill  = 5'(f);
    clr_err  = clr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  initial begin
    d_base = w(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    b1     = w(11, 12, 13, 14, 15, 16, 17, 18, 19, 20);
    b2     = w(21, 22, 23, 24, 25, 26, 27, 28, 29, 30);
    b3     = w(31, 30, 29, 28, 27, 26, 25, 24, 23, 22);

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ok", 64'(out_range_ok), 64'd1);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(d_base, 2, 0, 31);
    chk("rfill_k2_data", 64'(out_data), 64'(w(3, 4, 5, 6, 7, 8, 9, 10, 31, 31)));
    chk("rfill_k2_ok", 64'(out_range_ok), 64'd1);
    chk("rfill_k2_valid", 64'(out_valid), 64'd1);
    chk("rfill_k2_err", 64'(err_cnt), 64'd0);

    send(d_base, 3, 1, 0);
    chk("rarith_k3", 64'(out_data), 64'(w(4, 5, 6, 7, 8, 9, 10, 10, 10, 10)));
    send(d_base, 4, 1, 0);
    chk("rarith_k4", 64'(out_data), 64'(w(5, 6, 7, 8, 9, 10, 10, 10, 10, 10)));
    send(d_base, 4, 2, 0);
    chk("rot_k4", 64'(out_data), 64'(w(5, 6, 7, 8, 9, 10, 1, 2, 3, 4)));
    send(d_base, 1, 2, 0);
    chk("rot_k1", 64'(out_data), 64'(w(2, 3, 4, 5, 6, 7, 8, 9, 10, 1)));
    send(d_base, 1, 3, 0);
    chk("lfill_k1", 64'(out_data), 64'(w(0, 1, 2, 3, 4, 5, 6, 7, 8, 9)));
    send(d_base, 4, 3, 3);
    chk("lfill_k4", 64'(out_data), 64'(w(3, 3, 3, 3, 1, 2, 3, 4, 5, 6)));
    send(d_base, 0, 0, 7);
    chk("rfill_k0", 64'(out_data), 64'(d_base));
    send(d_base, 0, 3, 7);
    chk("lfill_k0", 64'(out_data), 64'(d_base));

    send(d_base, 7, 0, 21);
    chk("oor_rfill_data", 64'(out_data), 64'(w(21, 21, 21, 21, 21, 21, 21, 21, 21, 21)));
    chk("oor_rfill_ok", 64'(out_range_ok), 64'd0);
    chk("oor_rfill_err", 64'(err_cnt), 64'd1);
    send(d_base, 15, 1, 21);
    chk("oor_rarith_data", 64'(out_data), 64'(w(10, 10, 10, 10, 10, 10, 10, 10, 10, 10)));
    chk("oor_rarith_err", 64'(err_cnt), 64'd2);
    send(d_base, 5, 2, 21, 1'b1);
    chk("oor_rot_data", 64'(out_data), 64'(d_base));
    chk("clr_with_beat_err", 64'(err_cnt), 64'd1);
    @(posedge clk);
    #1;
    chk("idle_valid_drop", 64'(out_valid), 64'd0);
    chk("idle_ok_held", 64'(out_range_ok), 64'd0);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("clr_only_err", 64'(err_cnt), 64'd0);

    // Backpressure: beat 1 is taken, beat 2 waits while the output stalls.
    out_ready = 1'b0;
    send(b1, 0, 0, 0);
    in_data  = b2;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold_%0d", c), 64'(out_data), 64'(b1));
      chk($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_beat2", 64'(out_data), 64'(b2));
    in_data = b3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_beat3", 64'(out_data), 64'(b3));
    chk("bp_beat3_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    send(d_base, 9, 0, 1);
    send(d_base, 9, 0, 2);
    send(d_base, 9, 0, 3);
    chk("pre_rst_err", 64'(err_cnt), 64'd3);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_err", 64'(err_cnt), 64'd0);
    chk("arst_ok", 64'(out_range_ok), 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    send(d_base, 2, 0, 31);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'(w(3, 4, 5, 6, 7, 8, 9, 10, 31, 31)));
    chk("post_rst_err", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
